// File: rtl/pmem_pkg.sv
// Shared types and constants for the program-memory port arbiter.
// Holds the response tag carried from grant (c0) to data return (c1).
package pmem_pkg;

    localparam int PMEM_ADDR_W = 15;
    localparam int PMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DBG   = 2'd2
    } pmem_owner_e;

    typedef struct packed {
        pmem_owner_e owner;
        logic        is_read;
        logic        err;
    } pmem_rsp_tag_t;

    // A byte address is in range only if every bit above the word index is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned addr_w);
        return (addr >> (addr_w + 2)) == 32'd0;
    endfunction

endpackage

// File: rtl/pmem_starve_ctr.sv
// Saturating count of consecutive cycles the debug port asked and lost.
// When the count reaches the limit, debug is forced to win the next request.
module pmem_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_dbg
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt <= 4'd0;
        end else if (dbg_req && !dbg_gnt) begin
            if (starve_cnt != LIMIT) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end

    assign force_dbg = dbg_req && (starve_cnt == LIMIT);

endmodule

// File: rtl/pmem_port_arbiter.sv
// Shares a single-port program memory between instruction fetch (priority)
// and a debug/loader port, routing range-checked read data back one cycle later.
module pmem_port_arbiter
    import pmem_pkg::*;
#(
    parameter int ADDR_W       = PMEM_ADDR_W,
    parameter int DATA_W       = PMEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req_c0,
    input  logic [31:0]       fetch_addr_c0,
    output logic              fetch_gnt_c0,
    output logic              fetch_rvalid_c1,
    output logic [DATA_W-1:0] fetch_rdata_c1,
    output logic              fetch_err_c1,
    input  logic              dbg_req_c0,
    input  logic              dbg_we_c0,
    input  logic [31:0]       dbg_addr_c0,
    input  logic [DATA_W-1:0] dbg_wdata_c0,
    output logic              dbg_gnt_c0,
    output logic              dbg_rvalid_c1,
    output logic [DATA_W-1:0] dbg_rdata_c1,
    output logic              dbg_err_c1,
    output logic              mem_en_c0,
    output logic              mem_we_c0,
    output logic [ADDR_W-1:0] mem_addr_c0,
    output logic [DATA_W-1:0] mem_wdata_c0,
    input  logic [DATA_W-1:0] mem_rdata_c1
);

    logic          force_dbg;
    logic          fetch_in_range;
    logic          dbg_in_range;
    pmem_rsp_tag_t tag_c1;

    pmem_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .reset_n  (reset_n),
        .dbg_req  (dbg_req_c0),
        .dbg_gnt  (dbg_gnt_c0),
        .force_dbg(force_dbg)
    );

    assign fetch_in_range = addr_in_range(fetch_addr_c0, ADDR_W);
    assign dbg_in_range   = addr_in_range(dbg_addr_c0, ADDR_W);

    // Grants are gated by reset so nothing reaches memory while held in reset.
    assign dbg_gnt_c0   = reset_n && dbg_req_c0 && (!fetch_req_c0 || force_dbg);
    assign fetch_gnt_c0 = reset_n && fetch_req_c0 && !dbg_gnt_c0;

    assign mem_en_c0    = (fetch_gnt_c0 && fetch_in_range) || (dbg_gnt_c0 && dbg_in_range);
    assign mem_we_c0    = dbg_gnt_c0 && dbg_we_c0 && dbg_in_range;
    assign mem_addr_c0  = dbg_gnt_c0 ? dbg_addr_c0[ADDR_W+1:2] : fetch_addr_c0[ADDR_W+1:2];
    assign mem_wdata_c0 = dbg_wdata_c0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_c1 <= '0;
        end else if (dbg_gnt_c0) begin
            tag_c1.owner   <= OWN_DBG;
            tag_c1.is_read <= !dbg_we_c0;
            tag_c1.err     <= !dbg_in_range;
        end else if (fetch_gnt_c0) begin
            tag_c1.owner   <= OWN_FETCH;
            tag_c1.is_read <= 1'b1;
            tag_c1.err     <= !fetch_in_range;
        end else begin
            tag_c1 <= '0;
        end
    end

    // Read data is zeroed unless it belongs to a valid, in-range read.
    assign fetch_rvalid_c1 = (tag_c1.owner == OWN_FETCH);
    assign fetch_err_c1    = fetch_rvalid_c1 && tag_c1.err;
    assign fetch_rdata_c1  = (fetch_rvalid_c1 && !tag_c1.err) ? mem_rdata_c1 : '0;

    assign dbg_rvalid_c1 = (tag_c1.owner == OWN_DBG) && tag_c1.is_read;
    assign dbg_err_c1    = (tag_c1.owner == OWN_DBG) && tag_c1.err;
    assign dbg_rdata_c1  = (dbg_rvalid_c1 && !tag_c1.err) ? mem_rdata_c1 : '0;

endmodule

// File: tb/tb_pmem_port_arbiter.sv
// Scoreboard bench for pmem_port_arbiter with a behavioural 1-cycle memory.
// Expected responses are queued at grant time and compared one cycle later.
module tb_pmem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        fetch_req_c0;
    logic [31:0] fetch_addr_c0;
    logic        fetch_gnt_c0;
    logic        fetch_rvalid_c1;
    logic [31:0] fetch_rdata_c1;
    logic        fetch_err_c1;
    logic        dbg_req_c0;
    logic        dbg_we_c0;
    logic [31:0] dbg_addr_c0;
    logic [31:0] dbg_wdata_c0;
    logic        dbg_gnt_c0;
    logic        dbg_rvalid_c1;
    logic [31:0] dbg_rdata_c1;
    logic        dbg_err_c1;
    logic        mem_en_c0;
    logic        mem_we_c0;
    logic [14:0] mem_addr_c0;
    logic [31:0] mem_wdata_c0;
    logic [31:0] mem_rdata_c1;

    typedef struct {
        logic        fv;
        logic        fe;
        logic [31:0] fd;
        logic        dv;
        logic        de;
        logic [31:0] dd;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] mem     [0:32767];
    logic [31:0] ref_mem [0:32767];
    int          total;
    int          bad;

    pmem_port_arbiter #(
        .ADDR_W(15),
        .DATA_W(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fetch_req_c0   (fetch_req_c0),
        .fetch_addr_c0  (fetch_addr_c0),
        .fetch_gnt_c0   (fetch_gnt_c0),
        .fetch_rvalid_c1(fetch_rvalid_c1),
        .fetch_rdata_c1 (fetch_rdata_c1),
        .fetch_err_c1   (fetch_err_c1),
        .dbg_req_c0     (dbg_req_c0),
        .dbg_we_c0      (dbg_we_c0),
        .dbg_addr_c0    (dbg_addr_c0),
        .dbg_wdata_c0   (dbg_wdata_c0),
        .dbg_gnt_c0     (dbg_gnt_c0),
        .dbg_rvalid_c1  (dbg_rvalid_c1),
        .dbg_rdata_c1   (dbg_rdata_c1),
        .dbg_err_c1     (dbg_err_c1),
        .mem_en_c0      (mem_en_c0),
        .mem_we_c0      (mem_we_c0),
        .mem_addr_c0    (mem_addr_c0),
        .mem_wdata_c0   (mem_wdata_c0),
        .mem_rdata_c1   (mem_rdata_c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en_c0) begin
            if (mem_we_c0) mem[mem_addr_c0] <= mem_wdata_c0;
            else           mem_rdata_c1     <= mem[mem_addr_c0];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkResponse();
        rsp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("fetch_rvalid", 32'(fetch_rvalid_c1), 32'(e.fv));
            checkOutput("fetch_err",    32'(fetch_err_c1),    32'(e.fe));
            checkOutput("fetch_rdata",  fetch_rdata_c1,       e.fd);
            checkOutput("dbg_rvalid",   32'(dbg_rvalid_c1),   32'(e.dv));
            checkOutput("dbg_err",      32'(dbg_err_c1),      32'(e.de));
            checkOutput("dbg_rdata",    dbg_rdata_c1,         e.dd);
        end
    endtask

    task automatic applyStimulus(
        input logic        rst,
        input logic        rst_late,
        input logic        freq,
        input logic [31:0] faddr,
        input logic        dreq,
        input logic        dwe,
        input logic [31:0] daddr,
        input logic [31:0] dwdata,
        input logic        exp_f,
        input logic        exp_d
    );
        rsp_t        e;
        logic        f_in;
        logic        d_in;
        logic        exp_en;
        logic        exp_we;
        logic [14:0] exp_a;
        @(negedge clk);
        checkResponse();
        reset_n       = rst;
        fetch_req_c0  = freq;
        fetch_addr_c0 = faddr;
        dbg_req_c0    = dreq;
        dbg_we_c0     = dwe;
        dbg_addr_c0   = daddr;
        dbg_wdata_c0  = dwdata;
        #1;
        f_in   = (faddr[31:17] == 15'd0);
        d_in   = (daddr[31:17] == 15'd0);
        exp_en = (exp_f && f_in) || (exp_d && d_in);
        exp_we = exp_d && dwe && d_in;
        exp_a  = exp_d ? daddr[16:2] : faddr[16:2];
        checkOutput("fetch_gnt", 32'(fetch_gnt_c0), 32'(exp_f));
        checkOutput("dbg_gnt",   32'(dbg_gnt_c0),   32'(exp_d));
        checkOutput("mem_en",    32'(mem_en_c0),    32'(exp_en));
        checkOutput("mem_we",    32'(mem_we_c0),    32'(exp_we));
        if (exp_en) checkOutput("mem_addr", 32'(mem_addr_c0), 32'(exp_a));
        if (exp_we) checkOutput("mem_wdata", mem_wdata_c0, dwdata);
        e = '{fv: 1'b0, fe: 1'b0, fd: 32'd0, dv: 1'b0, de: 1'b0, dd: 32'd0};
        if (!rst_late) begin
            if (exp_f) begin
                e.fv = 1'b1;
                e.fe = !f_in;
                e.fd = f_in ? ref_mem[faddr[16:2]] : 32'd0;
            end
            if (exp_d) begin
                e.de = !d_in;
                if (dwe) begin
                    if (d_in) ref_mem[daddr[16:2]] = dwdata;
                end else begin
                    e.dv = 1'b1;
                    e.dd = d_in ? ref_mem[daddr[16:2]] : 32'd0;
                end
            end
        end
        exp_q.push_back(e);
        if (rst_late) begin
            #1;
            reset_n = 1'b0;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 32'hA000_0000 + 32'(i);
            ref_mem[i] = 32'hA000_0000 + 32'(i);
        end
        mem_rdata_c1  = 32'd0;
        reset_n       = 1'b0;
        fetch_req_c0  = 1'b0;
        fetch_addr_c0 = 32'd0;
        dbg_req_c0    = 1'b0;
        dbg_we_c0     = 1'b0;
        dbg_addr_c0   = 32'd0;
        dbg_wdata_c0  = 32'd0;

        // In reset: no grants even with both requesters asking.
        applyStimulus(0, 0, 1, 32'h0, 1, 0, 32'h10, 32'h0, 0, 0);
        applyStimulus(0, 0, 1, 32'h0, 1, 0, 32'h10, 32'h0, 0, 0);

        applyStimulus(1, 0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
        applyStimulus(1, 0, 1, 32'h4, 0, 0, 32'h0, 32'h0, 1, 0);
        applyStimulus(1, 0, 1, 32'h8, 0, 0, 32'h0, 32'h0, 1, 0);

        applyStimulus(1, 0, 0, 32'h0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 1);
        applyStimulus(1, 0, 0, 32'h0, 1, 0, 32'h10, 32'h0, 0, 1);

        applyStimulus(1, 0, 1, 32'h0002_0000, 0, 0, 32'h0, 32'h0, 1, 0);
        applyStimulus(1, 0, 1, 32'h7, 0, 0, 32'h0, 32'h0, 1, 0);

        // Both requesting: debug wins every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 1, 32'(i * 4), 1, 0, 32'h10, 32'h0, (i % 5) != 4, (i % 5) == 4);
        end

        applyStimulus(1, 0, 0, 32'h0, 1, 1, 32'h0004_0000, 32'h1234_5678, 0, 1);

        // Reset lands on the edge after a debug read grant.
        applyStimulus(1, 1, 0, 32'h0, 1, 0, 32'h10, 32'h0, 0, 1);
        applyStimulus(0, 0, 1, 32'h0, 1, 0, 32'h10, 32'h0, 0, 0);

        // Build up starvation, reset, then confirm the count restarted from zero.
        applyStimulus(1, 0, 1, 32'h0, 1, 0, 32'h14, 32'h0, 1, 0);
        applyStimulus(1, 0, 1, 32'h4, 1, 0, 32'h14, 32'h0, 1, 0);
        applyStimulus(0, 0, 1, 32'h8, 1, 0, 32'h14, 32'h0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 1, 32'(16 + i * 4), 1, 0, 32'h14, 32'h0, i != 4, i == 4);
        end

        applyStimulus(1, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        checkResponse();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
